secondsection: RTL and testbench

Operand-fetch stage of the single-cycle MIPS datapath, directly upstream of the ALU stage. It decodes register fields from the current instruction, holds the 32×32 general-purpose register file, and extends the 16-bit immediate. It drives the ALU operands `A` and `B`, plus the store data for the memory stage. It accepts the write-back result at the end of each instruction cycle.

---
 rtl/secondsection.sv | 111 +++++++++++
 tb/tb_secondsection.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/secondsection.sv
// -----------------------------------------------------------------------------
// secondsection
//   Operand-fetch stage of the single-cycle MIPS datapath. Decodes the register
//   fields of the current instruction, holds the general-purpose register file,
//   extends the 16-bit immediate and drives the ALU operands, the store data and
//   the resolved write-back address. The write-back result is captured on the
//   rising clock edge that ends each instruction cycle.
//
// Optional feature macro: SECONDSECTION_JAL_EN
//   When defined, the LINK and PC4 inputs are added. LINK=1 forces the write
//   address to R31 and writes PC4 instead of WRITE_DATA (REGWRITE still gates).
//
// Ports
//   CLK          in   system clock, state updates on rising edge
//   RST_N        in   asynchronous active-low reset, clears every register
//   INSTR[31:0]  in   instruction: rs=[25:21] rt=[20:16] rd=[15:11] imm=[15:0]
//   REGDST       in   write address select, 1 = rd, 0 = rt
//   ALUSRC       in   B operand select, 1 = extended immediate, 0 = R[rt]
//   EXTOP        in   1 = sign-extend imm, 0 = zero-extend imm
//   REGWRITE     in   write enable for the write-back port
//   WRITE_DATA   in   write-back value
//   DBG_ADDR     in   debug read address
//   LINK, PC4    in   (SECONDSECTION_JAL_EN only) link-register write
//   A            out  R[rs]
//   B            out  ALUSRC ? ext : R[rt]
//   RT_DATA      out  R[rt], store data
//   WREG         out  resolved write address
//   DBG_DATA     out  R[DBG_ADDR]
// -----------------------------------------------------------------------------
module secondsection #(
  parameter int WIDTH = 32,
  parameter int NREGS = 32
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic [31:0]      INSTR,
  input  logic             REGDST,
  input  logic             ALUSRC,
  input  logic             EXTOP,
  input  logic             REGWRITE,
  input  logic [WIDTH-1:0] WRITE_DATA,
  input  logic [4:0]       DBG_ADDR,
`ifdef SECONDSECTION_JAL_EN
  input  logic             LINK,
  input  logic [WIDTH-1:0] PC4,
`endif
  output logic [WIDTH-1:0] A,
  output logic [WIDTH-1:0] B,
  output logic [WIDTH-1:0] RT_DATA,
  output logic [4:0]       WREG,
  output logic [WIDTH-1:0] DBG_DATA
);

  logic [WIDTH-1:0] r_regs [NREGS];

  logic [4:0]       w_rs;
  logic [4:0]       w_rt;
  logic [4:0]       w_rd;
  logic [15:0]      w_imm;
  logic [WIDTH-1:0] w_ext;
  logic [4:0]       w_wreg;
  logic [WIDTH-1:0] w_wdata;
  logic             w_unused_opcode;

  assign w_rs  = INSTR[25:21];
  assign w_rt  = INSTR[20:16];
  assign w_rd  = INSTR[15:11];
  assign w_imm = INSTR[15:0];

  // The opcode field is decoded elsewhere; it is not needed in this stage.
  assign w_unused_opcode = ^INSTR[31:26];

  // Address 0 (and anything beyond the implemented registers) reads as zero,
  // so R0 stays hardwired regardless of what the storage holds.
  function automatic logic [WIDTH-1:0] rd_port(input logic [4:0] addr);
    if (addr == 5'd0 || int'(addr) >= NREGS) return '0;
    return r_regs[addr];
  endfunction

  always_comb begin
    w_ext = EXTOP ? {{(WIDTH-16){w_imm[15]}}, w_imm} : {{(WIDTH-16){1'b0}}, w_imm};
  end

  always_comb begin
    w_wreg  = REGDST ? w_rd : w_rt;
    w_wdata = WRITE_DATA;
`ifdef SECONDSECTION_JAL_EN
    // Link writes always target the return-address register.
    if (LINK) begin
      w_wreg  = 5'd31;
      w_wdata = PC4;
    end
`endif
  end

  // No write-to-read bypass: reads see the stored value until the edge.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      for (int i = 0; i < NREGS; i++) r_regs[i] <= '0;
    end else if (REGWRITE && w_wreg != 5'd0 && int'(w_wreg) < NREGS) begin
      r_regs[w_wreg] <= w_wdata;
    end
  end

  assign A        = rd_port(w_rs);
  assign RT_DATA  = rd_port(w_rt);
  assign DBG_DATA = rd_port(DBG_ADDR);
  assign B        = ALUSRC ? w_ext : RT_DATA;
  assign WREG     = w_wreg;

endmodule

// File: tb/tb_secondsection.sv
module tb_secondsection;

  logic        CLK = 1'b0;
  logic        RST_N;
  logic [31:0] INSTR;
  logic        REGDST;
  logic        ALUSRC;
  logic        EXTOP;
  logic        REGWRITE;
  logic [31:0] WRITE_DATA;
  logic [4:0]  DBG_ADDR;
`ifdef SECONDSECTION_JAL_EN
  logic        LINK;
  logic [31:0] PC4;
`endif
  logic [31:0] A;
  logic [31:0] B;
  logic [31:0] RT_DATA;
  logic [4:0]  WREG;
  logic [31:0] DBG_DATA;

  int errors = 0;
  int checks = 0;

  secondsection #(.WIDTH(32), .NREGS(32)) dut (
    .CLK(CLK),
    .RST_N(RST_N),
    .INSTR(INSTR),
    .REGDST(REGDST),
    .ALUSRC(ALUSRC),
    .EXTOP(EXTOP),
    .REGWRITE(REGWRITE),
    .WRITE_DATA(WRITE_DATA),
    .DBG_ADDR(DBG_ADDR),
`ifdef SECONDSECTION_JAL_EN
    .LINK(LINK),
    .PC4(PC4),
`endif
    .A(A),
    .B(B),
    .RT_DATA(RT_DATA),
    .WREG(WREG),
    .DBG_DATA(DBG_DATA)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  function automatic logic [31:0] mk(input logic [4:0] rs, input logic [4:0] rt,
                                     input logic [15:0] imm);
    return {6'd0, rs, rt, imm};
  endfunction

  // Write one register through the rt form.
  task automatic wr(input logic [4:0] addr, input logic [31:0] data);
    INSTR      = mk(5'd0, addr, 16'h0000);
    REGDST     = 1'b0;
    WRITE_DATA = data;
    REGWRITE   = 1'b1;
    tick();
    REGWRITE   = 1'b0;
  endtask

  initial begin
    RST_N = 1'b1; INSTR = '0; REGDST = 1'b0; ALUSRC = 1'b0; EXTOP = 1'b0;
    REGWRITE = 1'b0; WRITE_DATA = '0; DBG_ADDR = '0;
`ifdef SECONDSECTION_JAL_EN
    LINK = 1'b0; PC4 = '0;
`endif

    // Reset mid-cycle while a write is being presented (rd = imm[15:11] = 5).
    #2;
    INSTR = mk(5'd5, 5'd6, 16'h2800); REGDST = 1'b1; REGWRITE = 1'b1;
    WRITE_DATA = 32'hDEADBEEF; ALUSRC = 1'b1; EXTOP = 1'b1;
    RST_N = 1'b0;
    #1;
    chk("rst_A", A, 32'h0);
    chk("rst_RT", RT_DATA, 32'h0);
    chk("rst_WREG", WREG, 32'd5);
    chk("rst_B_ext", B, 32'h00002800);
    ALUSRC = 1'b0;
    #1;
    chk("rst_B_reg", B, 32'h0);
    tick(); tick();
    for (int i = 0; i < 32; i++) begin
      DBG_ADDR = 5'(i);
      #1;
      chk($sformatf("rst_dbg%0d", i), DBG_DATA, 32'h0);
    end

    // Release reset mid-cycle with no write pending.
    @(negedge CLK);
    REGWRITE = 1'b0;
    RST_N = 1'b1;
    tick();

    // Write R5 through the rd form, then read it on A.
    INSTR = mk(5'd0, 5'd0, {5'd5, 11'd0}); REGDST = 1'b1;
    WRITE_DATA = 32'h12345678; REGWRITE = 1'b1;
    #1;
    chk("rd_WREG", WREG, 32'd5);
    tick();
    REGWRITE = 1'b0; REGDST = 1'b0;
    INSTR = mk(5'd5, 5'd0, 16'h0);
    #1;
    chk("rd_A", A, 32'h12345678);

    // R0 protection.
    wr(5'd0, 32'hFFFFFFFF);
    INSTR = mk(5'd0, 5'd0, 16'h0); DBG_ADDR = 5'd0;
    #1;
    chk("r0_A", A, 32'h0);
    chk("r0_RT", RT_DATA, 32'h0);
    chk("r0_DBG", DBG_DATA, 32'h0);

    // Extension and B mux.
    wr(5'd7, 32'd7);
    INSTR = mk(5'd0, 5'd7, 16'h8000); ALUSRC = 1'b1; EXTOP = 1'b1;
    #1;
    chk("ext_sign", B, 32'hFFFF8000);
    EXTOP = 1'b0;
    #1;
    chk("ext_zero", B, 32'h00008000);
    INSTR = mk(5'd0, 5'd7, 16'h7FFF); EXTOP = 1'b1;
    #1;
    chk("ext_pos", B, 32'h00007FFF);
    ALUSRC = 1'b0;
    #1;
    chk("b_reg", B, 32'd7);
    chk("rt_data7", RT_DATA, 32'd7);

    // Read during write, then REGWRITE=0 holds the value.
    wr(5'd3, 32'd1);
    INSTR = mk(5'd3, 5'd3, 16'h0); REGDST = 1'b0;
    WRITE_DATA = 32'd2; REGWRITE = 1'b1;
    #1;
    chk("rdw_pre", A, 32'd1);
    tick();
    chk("rdw_post", A, 32'd2);
    REGWRITE = 1'b0; WRITE_DATA = 32'd9;
    tick();
    chk("rdw_hold", A, 32'd2);

    // Back-to-back writes to one register.
    INSTR = mk(5'd0, 5'd8, 16'h0); DBG_ADDR = 5'd8;
    WRITE_DATA = 32'h000000AA; REGWRITE = 1'b1;
    tick();
    chk("b2b_1", DBG_DATA, 32'h000000AA);
    WRITE_DATA = 32'h000000BB;
    tick();
    chk("b2b_2", DBG_DATA, 32'h000000BB);
    REGWRITE = 1'b0;

`ifdef SECONDSECTION_JAL_EN
    wr(5'd4, 32'h00000044);
    INSTR = mk(5'd0, 5'd0, {5'd4, 11'd0}); REGDST = 1'b1;
    LINK = 1'b1; PC4 = 32'h00400008; WRITE_DATA = 32'h11111111; REGWRITE = 1'b1;
    #1;
    chk("jal_WREG", WREG, 32'd31);
    tick();
    REGWRITE = 1'b0; LINK = 1'b0; REGDST = 1'b0;
    DBG_ADDR = 5'd31;
    #1;
    chk("jal_r31", DBG_DATA, 32'h00400008);
    DBG_ADDR = 5'd4;
    #1;
    chk("jal_r4", DBG_DATA, 32'h00000044);
`endif

    // Asynchronous reset clears stored state without a clock edge.
    DBG_ADDR = 5'd5;
    #1;
    chk("pre_async", DBG_DATA, 32'h12345678);
    @(negedge CLK);
    #1;
    RST_N = 1'b0;
    #1;
    chk("async_clr", DBG_DATA, 32'h0);
    DBG_ADDR = 5'd3;
    #1;
    chk("async_clr3", DBG_DATA, 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
